// File: rtl/vga_adj_pkg.sv
// Shared types for the VGA clock adjust controller: FSM states and button priority.
package vga_adj_pkg;

  localparam int unsigned N_BTN   = 3;
  localparam int unsigned IDX_HRS = 2;
  localparam int unsigned IDX_MIN = 1;
  localparam int unsigned IDX_SEC = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_DELAY,
    ST_REPEAT,
    ST_RELEASE
  } adj_state_e;

  // One-hot grant of the highest-priority active level: hrs > min > sec.
  function automatic logic [N_BTN-1:0] prio_grant(input logic [N_BTN-1:0] lvl);
    prio_grant = '0;
    if (lvl[IDX_HRS])      prio_grant[IDX_HRS] = 1'b1;
    else if (lvl[IDX_MIN]) prio_grant[IDX_MIN] = 1'b1;
    else if (lvl[IDX_SEC]) prio_grant[IDX_SEC] = 1'b1;
  endfunction

endpackage

// File: rtl/vga_adj_debounce.sv
// Two-flop synchroniser followed by a restartable stable-level debouncer.
module vga_adj_debounce import vga_adj_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic clean_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;

  // Count consecutive cycles the synced level disagrees with the clean level.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync_q[1] != clean_q) begin
      if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
        clean_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/vga_adj_ctrl.sv
// Adjust-button controller: debounced buttons, priority grant, first pulse plus auto-repeat.
module vga_adj_ctrl import vga_adj_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic btn_hrs,
  input  logic btn_min,
  input  logic btn_sec,
  output logic adj_hrs,
  output logic adj_min,
  output logic adj_sec,
  output logic busy
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [N_BTN-1:0] btn_raw, clean;
  adj_state_e       state_q, state_d;
  logic [N_BTN-1:0] grant_q, grant_d;
  logic [N_BTN-1:0] adj_q, adj_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             busy_q;
  logic             held;

  assign btn_raw = {btn_hrs, btn_min, btn_sec};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    vga_adj_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .btn_i  (btn_raw[g]),
      .clean_o(clean[g])
    );
  end

  assign held = |(clean & grant_q);

  // Next-state, grant, repeat timer and pulse selection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    timer_d = timer_q;
    adj_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|clean) begin
          grant_d = prio_grant(clean);
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (!held) begin
          state_d = ST_RELEASE;
        end else begin
          adj_d   = grant_q;
          timer_d = TW'(REPEAT_DELAY);
          state_d = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!held) begin
          state_d = ST_RELEASE;
        end else if (timer_q == TW'(1)) begin
          adj_d   = grant_q;
          timer_d = TW'(REPEAT_PERIOD);
          state_d = ST_REPEAT;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_RELEASE: begin
        timer_d = '0;
        if (clean == '0) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      timer_q <= '0;
      adj_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      adj_q   <= adj_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign adj_hrs = adj_q[IDX_HRS];
  assign adj_min = adj_q[IDX_MIN];
  assign adj_sec = adj_q[IDX_SEC];
  assign busy    = busy_q;

endmodule

// File: tb/tb_vga_adj_ctrl.sv
// Directed bench for vga_adj_ctrl with short debounce/repeat parameters.
module tb_vga_adj_ctrl;

  logic clk = 1'b0;
  logic rst, bh, bm, bs;
  logic adj_hrs, adj_min, adj_sec, busy;
  logic [3:0] obs;
  logic [2:0] prev_adj;
  logic [3:0] want;
  int total = 0;
  int bad   = 0;

  assign obs = {busy, adj_hrs, adj_min, adj_sec};

  always #5 clk = ~clk;

  vga_adj_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .btn_hrs (bh),
    .btn_min (bm),
    .btn_sec (bs),
    .adj_hrs (adj_hrs),
    .adj_min (adj_min),
    .adj_sec (adj_sec),
    .busy    (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int i, input logic [3:0] o, input logic [3:0] w);
    total++;
    assert (o === w) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, i, o, w);
    end
  endtask

  // Reset with buttons low; returns just after the last reset edge (reference step 0).
  task automatic do_reset();
    rst = 1'b1; bh = 1'b0; bm = 1'b0; bs = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bh = 1'b0; bm = 1'b0; bs = 1'b0;
    prev_adj = '0;
    step();
    chk("reset_first_edge", 0, obs, 4'b0000);
    step();
    chk("reset_held", 0, obs, 4'b0000);
    rst = 1'b0;

    // Clean min press, held through step 28: pulses 8, then 18 and every 3 until release lands.
    bm = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      want = {(i >= 7 && i <= 35), 1'b0,
              (i == 8) || (i >= 18 && i <= 33 && (i - 18) % 3 == 0), 1'b0};
      chk("min_hold", i, obs, want);
      if (i == 28) bm = 1'b0;
    end

    // Sec bouncing every 2 cycles never debounces.
    do_reset();
    bs = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("sec_bounce", i, obs, 4'b0000);
      bs = (i < 20) && (((i >> 1) & 1) == 0);
    end

    // Hrs and sec together: hrs wins; sec locked out until all released and re-pressed.
    do_reset();
    bh = 1'b1; bs = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      want = {((i >= 7 && i <= 36) || i >= 47), (i == 8), 1'b0, (i == 48)};
      chk("hrs_vs_sec", i, obs, want);
      if (i == 9)  bh = 1'b0;
      if (i == 30) bs = 1'b0;
      if (i == 40) bs = 1'b1;
    end

    // Reset pulse right as the second min pulse is visible, button still held.
    do_reset();
    bm = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      step();
      if (i <= 18)
        want = {(i >= 7), 1'b0, (i == 8 || i == 18), 1'b0};
      else
        want = {(i >= 26), 1'b0, (i == 27), 1'b0};
      chk("reset_in_repeat", i, obs, want);
      rst = (i == 18);
    end

    // Release timed so the clean level drops exactly when the third pulse is due.
    do_reset();
    bm = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      want = {(i >= 7 && i <= 24), 1'b0, (i == 8 || i == 18 || i == 21), 1'b0};
      chk("release_on_due", i, obs, want);
      if (i == 17) bm = 1'b0;
    end

    // Random button activity: one-hot-or-zero pulses, never two cycles wide.
    do_reset();
    for (int i = 1; i <= 3000; i++) begin
      if ($urandom_range(0, 11) == 0) bh = ~bh;
      if ($urandom_range(0, 11) == 0) bm = ~bm;
      if ($urandom_range(0, 11) == 0) bs = ~bs;
      step();
      chk("onehot0", i, {3'b000, $onehot0(obs[2:0])}, 4'b0001);
      chk("pulse_width", i, {1'b0, obs[2:0] & prev_adj}, 4'b0000);
      prev_adj = obs[2:0];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
